md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: reset is sampled only on the rising clock edge and asserts when low.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the maximum number of WAIT cycles before abort.
REQ-003 Parameter RSTATUS_REG, default 30, SHALL set the register index written on an exception.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  decode presents a mul/div instruction.
REQ-007 req_op  in  1  0=mul, 1=div.
REQ-008 req_a, req_b  in  32 each  signed operands.
REQ-009 req_rd  in  5  destination register.
REQ-010 req_ready  out  1  request accepted this cycle when high together with req_valid.
REQ-011 stall  out  1  freeze fetch/decode.
REQ-012 mul_start, div_start  out  1 each  one-cycle start pulses to the units.
REQ-013 unit_a, unit_b  out  32 each  latched operands driven to both units.
REQ-014 unit_clear  out  1  active-high clear to both units.
REQ-015 mul_done, mul_overflow  in  1 each; mul_result  in  32.
REQ-016 div_done, div_exception  in  1 each; div_result  in  32.
REQ-017 wb_valid  out  1  one-cycle writeback strobe.
REQ-018 wb_rd  out  5  writeback register index.
REQ-019 wb_data  out  32  writeback value.
REQ-020 timeout  out  1  one-cycle abort pulse.

Function
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT and WB.
REQ-022 req_ready SHALL equal 1 only in IDLE; req_valid&&req_ready SHALL latch op, a, b and rd, then move to ISSUE.
REQ-023 In ISSUE, the block SHALL assert exactly one of mul_start or div_start for exactly one cycle, selected by the latched op, then move to WAIT.
REQ-024 unit_a and unit_b SHALL hold the latched operands from ISSUE through WB and SHALL be stable while start is high.
REQ-025 In WAIT, only the done input of the selected unit SHALL be honoured; the done input of the other unit and any done during ISSUE SHALL be ignored.
REQ-026 Selected done high in WAIT SHALL capture the result and exception flag and move to WB on the next edge.
REQ-027 In WB, wb_valid SHALL be high for one cycle, and the FSM SHALL then return to IDLE.
REQ-028 No exception in WB: wb_rd = latched rd and wb_data = result; rd=0 SHALL still pulse wb_valid with wb_rd=0.
REQ-029 Exception in WB (mul_overflow or div_exception): wb_rd = RSTATUS_REG, and wb_data = 32'd4 for mul or 32'd5 for div.
REQ-030 stall SHALL be high in ISSUE, WAIT and WB, and also in IDLE in the cycle a request is accepted.
REQ-031 Minimum latency from acceptance to wb_valid SHALL be 3 cycles (ISSUE, WAIT with done, WB).
REQ-032 A 7-bit WAIT counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-033 If the counter reaches TIMEOUT without done, the block SHALL pulse timeout and unit_clear for one cycle, produce no wb_valid, and go to IDLE.
REQ-034 Outside ISSUE, the block SHALL hold mul_start and div_start low.
REQ-035 In IDLE, wb_data and wb_rd SHALL hold their last values; they are meaningful only while wb_valid is high.
REQ-036 When done and the timeout condition occur in the same cycle, done SHALL win and the block SHALL go to WB.
REQ-037 The block SHALL accept back-to-back requests: a request is accepted in the IDLE cycle immediately after WB.

Reset
REQ-038 While reset=0 at an edge: state=IDLE; all start, wb_valid, timeout and stall outputs = 0; wb_rd = 0; wb_data = 0; unit_a = 0; unit_b = 0; counter = 0.
REQ-039 unit_clear SHALL equal ~reset combinationally, in addition to the timeout pulse.
REQ-040 Reset asserted in any state SHALL abort the operation with no wb_valid; req_ready = 1 on the first cycle after reset deasserts.

Verification
REQ-041 Mul 7 x -6, unit done one cycle after start -> mul_start for one cycle, wb_valid three cycles after acceptance, wb_rd = req_rd, wb_data = 0xFFFFFFD6.
REQ-042 Mul 0x40000000 x 4 with mul_overflow=1 -> wb_rd = 30, wb_data = 4, and stall deasserts after WB.
REQ-043 Div 100 / 0 with div_done after 33 cycles and div_exception=1 -> wb_rd = 30, wb_data = 5; a mul_done pulse injected during WAIT is ignored.
REQ-044 Div with no done -> timeout and unit_clear pulse on WAIT cycle 64, wb_valid never asserts, and req_ready = 1 the next cycle.
REQ-045 Reset driven low during WAIT -> the next cycle shows IDLE, stall = 0, unit_clear = 1 while reset is low, and a late done pulse produces no wb_valid.
REQ-046 req_valid held high for two back-to-back muls -> second accepted in the cycle after the first WB, two wb_valid pulses, and req_ready = 0 between them.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// Issue/writeback sequencer for an external multiplier and divider.
// It accepts one request, starts the selected unit, waits for done or a timeout, then writes back.
module md_issue_ctrl #(
    parameter int TIMEOUT     = 64,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        stall,
    output logic        mul_start,
    output logic        div_start,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_clear,
    input  logic        mul_done,
    input  logic        mul_overflow,
    input  logic [31:0] mul_result,
    input  logic        div_done,
    input  logic        div_exception,
    input  logic [31:0] div_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t      state, state_nx;
    logic        op_q;
    logic [4:0]  rd_q;
    logic [6:0]  wait_cnt;
    logic        sel_done, sel_exc, wait_expired;
    logic [31:0] sel_result;

    // Only the unit that was started is listened to.
    assign sel_done     = op_q ? div_done      : mul_done;
    assign sel_exc      = op_q ? div_exception : mul_overflow;
    assign sel_result   = op_q ? div_result    : mul_result;
    assign wait_expired = (wait_cnt == 7'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (req_valid) state_nx = ISSUE;
            ISSUE: state_nx = WAIT;
            WAIT: begin
                // done beats an expiring counter in the same cycle
                if (sel_done)          state_nx = WB;
                else if (wait_expired) state_nx = IDLE;
            end
            WB:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        stall      = reset && ((state != IDLE) || req_valid);
        mul_start  = reset && (state == ISSUE) && !op_q;
        div_start  = reset && (state == ISSUE) && op_q;
        wb_valid   = reset && (state == WB);
        timeout    = reset && (state == WAIT) && !sel_done && wait_expired;
        unit_clear = !reset || timeout;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            op_q     <= 1'b0;
            rd_q     <= '0;
            unit_a   <= '0;
            unit_b   <= '0;
            wait_cnt <= '0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                op_q   <= req_op;
                rd_q   <= req_rd;
                unit_a <= req_a;
                unit_b <= req_b;
            end
            if (state == ISSUE)     wait_cnt <= '0;
            else if (state == WAIT) wait_cnt <= wait_cnt + 7'd1;
            // Writeback value is resolved at capture so WB just presents registers.
            if (state == WAIT && sel_done) begin
                wb_rd   <= sel_exc ? 5'(RSTATUS_REG) : rd_q;
                wb_data <= sel_exc ? (op_q ? 32'd5 : 32'd4) : sel_result;
            end
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: acts as both arithmetic units and predicts each writeback
// from the operation's arithmetic and the exception/timeout rules.
module tb_md_issue_ctrl;
    localparam int TIMEOUT = 64;

    logic        clock = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_op = 1'b0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [4:0]  req_rd = '0;
    logic        req_ready, stall, mul_start, div_start, unit_clear, wb_valid, timeout;
    logic [31:0] unit_a, unit_b, wb_data;
    logic [4:0]  wb_rd;
    logic        mul_done = 1'b0, mul_overflow = 1'b0, div_done = 1'b0, div_exception = 1'b0;
    logic [31:0] mul_result = '0, div_result = '0;

    int errs = 0, checks = 0;

    md_issue_ctrl #(.TIMEOUT(TIMEOUT), .RSTATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .req_ready(req_ready),
        .stall(stall), .mul_start(mul_start), .div_start(div_start),
        .unit_a(unit_a), .unit_b(unit_b), .unit_clear(unit_clear),
        .mul_done(mul_done), .mul_overflow(mul_overflow), .mul_result(mul_result),
        .div_done(div_done), .div_exception(div_exception), .div_result(div_result),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .timeout(timeout)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_units();
        mul_done = 0; div_done = 0; mul_overflow = 0; div_exception = 0;
        mul_result = $urandom; div_result = $urandom;
    endtask

    // What a real unit would return for the operands.
    function automatic logic [31:0] unit_value(input bit op, input logic [31:0] a, input logic [31:0] b);
        if (!op) return a * b;
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
    endfunction

    // One full transaction starting in an IDLE cycle; k = WAIT cycle of done (0 = never).
    task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input bit exc,
                          input bit noise, input bit hold);
        logic [31:0] res, exp_data;
        logic [4:0]  exp_rd;
        logic [1:0]  exp_start;
        int          last;
        bit          to_exp;
        res       = unit_value(op, a, b);
        exp_data  = exc ? (op ? 32'd5 : 32'd4) : res;
        exp_rd    = exc ? 5'd30 : rd;
        exp_start = op ? 2'b01 : 2'b10;

        checks++; if (req_ready !== 1'b1) begin errs++; $display("FAIL idle_ready: got %b want 1", req_ready); end
        req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
        #1;
        checks++; if (stall !== 1'b1) begin errs++; $display("FAIL accept_stall: got %b want 1", stall); end
        step();
        if (!hold) begin
            req_valid = 0; req_op = $urandom; req_a = $urandom; req_b = $urandom; req_rd = $urandom;
        end
        if (noise) begin
            mul_done = 1; div_done = 1; mul_overflow = 1; div_exception = 1;
            mul_result = $urandom; div_result = $urandom;
        end
        #1;
        checks++; if ({mul_start, div_start} !== exp_start) begin errs++; $display("FAIL issue_start: got %b want %b", {mul_start, div_start}, exp_start); end
        checks++; if (unit_a !== a || unit_b !== b) begin errs++; $display("FAIL issue_operands: got %h/%h want %h/%h", unit_a, unit_b, a, b); end
        checks++; if (req_ready !== 1'b0 || stall !== 1'b1) begin errs++; $display("FAIL issue_ready_stall: got %b%b want 01", req_ready, stall); end
        step();

        last = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            quiet_units();
            if (noise && i == 1) begin
                if (op) begin mul_done = 1; mul_overflow = 1; end
                else    begin div_done = 1; div_exception = 1; end
            end
            if (i == k) begin
                if (op) begin div_done = 1; div_exception = exc; div_result = res; end
                else    begin mul_done = 1; mul_overflow = exc; mul_result = res; end
            end
            #1;
            to_exp = (i == TIMEOUT) && (i != k);
            checks++; if ((mul_start | div_start) !== 1'b0 || stall !== 1'b1 || wb_valid !== 1'b0 || unit_a !== a || unit_b !== b)
                begin errs++; $display("FAIL wait_outputs cyc%0d: got st=%b%b stall=%b wb=%b a=%h b=%h want 00 1 0 %h %h", i, mul_start, div_start, stall, wb_valid, unit_a, unit_b, a, b); end
            checks++; if (timeout !== to_exp || unit_clear !== to_exp)
                begin errs++; $display("FAIL wait_timeout cyc%0d: got to=%b clr=%b want %b", i, timeout, unit_clear, to_exp); end
            last = i;
            if (i == k || i == TIMEOUT) break;
            step();
        end

        step();
        quiet_units();
        #1;
        if (last != k) begin
            checks++; if (req_ready !== 1'b1 || wb_valid !== 1'b0 || timeout !== 1'b0)
                begin errs++; $display("FAIL after_timeout: got rdy=%b wb=%b to=%b want 1 0 0", req_ready, wb_valid, timeout); end
        end else begin
            checks++; if (wb_valid !== 1'b1 || req_ready !== 1'b0 || stall !== 1'b1)
                begin errs++; $display("FAIL wb_strobe: got wb=%b rdy=%b stall=%b want 1 0 1", wb_valid, req_ready, stall); end
            checks++; if (wb_rd !== exp_rd || wb_data !== exp_data)
                begin errs++; $display("FAIL wb_value: got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, exp_rd, exp_data); end
            step();
            #1;
            checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1 || stall !== hold || wb_data !== exp_data || wb_rd !== exp_rd)
                begin errs++; $display("FAIL post_wb: got wb=%b rdy=%b stall=%b data=%h rd=%0d want 0 1 %b %h %0d", wb_valid, req_ready, stall, wb_data, wb_rd, hold, exp_data, exp_rd); end
        end
    endtask

    task automatic test_reset();
        reset = 0; req_valid = 1;
        step(); step();
        checks++; if (stall !== 0 || mul_start !== 0 || div_start !== 0 || wb_valid !== 0 || timeout !== 0)
            begin errs++; $display("FAIL reset_ctrl: got stall=%b st=%b%b wb=%b to=%b want all 0", stall, mul_start, div_start, wb_valid, timeout); end
        checks++; if (wb_rd !== 0 || wb_data !== 0 || unit_a !== 0 || unit_b !== 0)
            begin errs++; $display("FAIL reset_data: got rd=%0d data=%h a=%h b=%h want 0", wb_rd, wb_data, unit_a, unit_b); end
        checks++; if (unit_clear !== 1'b1 || req_ready !== 1'b1)
            begin errs++; $display("FAIL reset_clear: got clr=%b rdy=%b want 1 1", unit_clear, req_ready); end
        req_valid = 0; reset = 1;
        #1;
        checks++; if (unit_clear !== 1'b0 || req_ready !== 1'b1)
            begin errs++; $display("FAIL reset_release: got clr=%b rdy=%b want 0 1", unit_clear, req_ready); end
    endtask

    task automatic test_directed();
        run_op(0, 32'd7, 32'hFFFF_FFFA, 5'd12, 1, 0, 0, 0);
        run_op(0, 32'h4000_0000, 32'd4, 5'd9, 1, 1, 0, 0);
        run_op(1, 32'd100, 32'd0, 5'd3, 33, 1, 1, 0);
        run_op(0, 32'd5, 32'd6, 5'd0, 2, 0, 0, 0);
        run_op(1, 32'd1000, 32'd7, 5'd17, TIMEOUT, 0, 0, 0);
    endtask

    task automatic test_timeout();
        run_op(1, 32'd55, 32'd11, 5'd4, 0, 0, 0, 0);
    endtask

    task automatic test_reset_in_wait();
        req_valid = 1; req_op = 1; req_a = 32'd81; req_b = 32'd9; req_rd = 5'd6;
        step();
        req_valid = 0;
        step(); step(); step();
        reset = 0;
        #1;
        checks++; if (unit_clear !== 1'b1) begin errs++; $display("FAIL rst_wait_clear: got %b want 1", unit_clear); end
        step();
        checks++; if (req_ready !== 1'b1 || stall !== 1'b0 || wb_valid !== 1'b0 || unit_a !== 0)
            begin errs++; $display("FAIL rst_wait_idle: got rdy=%b stall=%b wb=%b a=%h want 1 0 0 0", req_ready, stall, wb_valid, unit_a); end
        reset = 1;
        div_done = 1; div_result = 32'd9; mul_done = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            quiet_units();
            #1;
            checks++; if (wb_valid !== 1'b0 || req_ready !== 1'b1)
                begin errs++; $display("FAIL rst_late_done cyc%0d: got wb=%b rdy=%b want 0 1", i, wb_valid, req_ready); end
        end
    endtask

    task automatic test_back_to_back();
        run_op(0, 32'd3, 32'd4, 5'd1, 1, 0, 0, 1);
        run_op(0, 32'hFFFF_FFFF, 32'd9, 5'd2, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            run_op($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   5'($urandom), $urandom_range(1, 6), $urandom_range(0, 1),
                   $urandom_range(0, 1), (n != 19) && ($urandom_range(0, 2) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
